pin_in_sync: RTL and testbench
==============================

# pin_in_sync

Per-pin input conditioning stage between the I/O pads and the pin multiplexer's pad-input port. Each pad input is double-flop synchronized into `clk`, optionally glitch-filtered by a per-pin stability counter, and edge-detected. The conditioned level `sync_out` drives the pin mux `io_in`, so every peripheral sees a clean, synchronous level. Per-pin rise and fall pulses, plus optional sticky event flags, are provided for interrupt logic.

## Interface
- `COUNT`, 32, number of pins; matches the pin mux `COUNT`.
- `FLT_W`, 4, width of the filter threshold and of each per-pin counter.

- `clk` input 1: single clock domain.
- `rst` input 1: reset; one clock; reset is asynchronous and active-high.
- `io_in` input COUNT: raw pad inputs, asynchronous to `clk`.
- `flt_en` input COUNT: per-pin filter enable; 0 = bypass.
- `flt_len` input FLT_W: global filter threshold N, shared by all pins.
- `sync_out` output COUNT: conditioned level; goes to the pin mux `io_in`.
- `rise` output COUNT: 1-cycle pulse when `sync_out[i]` goes 0->1.
- `fall` output COUNT: 1-cycle pulse when `sync_out[i]` goes 1->0.
- `ev_clr` input COUNT: per-pin clear of the sticky event flag.
- `ev_flag` output COUNT: sticky edge-event flag; see Configuration.

## Operation
- Reset: `s1`, `s2`, `sync_out`, `cnt`, `rise`, `fall` and `ev_flag` are all 0.
- Synchronizer: each clock, `s1[i]` <= `io_in[i]` and `s2[i]` <= `s1[i]`. No logic sits between the two flops.
- Filter, per pin, evaluated each clock:
  - If `flt_en[i]`=0: `sync_out[i]` <= `s2[i]` and `cnt[i]` <= 0.
  - If `flt_en[i]`=1 and `s2[i]`==`sync_out[i]`: `cnt[i]` <= 0.
  - If `flt_en[i]`=1, `s2[i]`!=`sync_out[i]` and `cnt[i]` >= `flt_len`: `sync_out[i]` <= `s2[i]` and `cnt[i]` <= 0.
  - Otherwise: `cnt[i]` <= `cnt[i]`+1.
- Filter consequences:
  - A change is accepted only after `s2` has held the new value for N+1 consecutive samples.
  - Any return to the old value restarts the count.
  - `cnt` never exceeds 2^FLT_W-1, because it is cleared on acceptance at N <= 2^FLT_W-1.
- Boundary cases:
  - `flt_len`=0 behaves exactly like bypass.
  - `flt_len` lowered mid-count below the current `cnt`: the change is accepted on the next clock (`>=` compare).
  - `flt_en` deasserted mid-count: `cnt` clears and `sync_out` follows `s2` on the next clock.
- Edge detect: `rise[i]` <= `~sync_out[i] & next_sync_out[i]`, and `fall[i]` is the complement case. Each pulse is registered, so it is high in the same cycle `sync_out` first shows the new value, for exactly one cycle.
- An `io_in` held at 1 through reset release produces one `rise` pulse when `sync_out` reaches 1.
- Pins are fully independent; no shared state except `flt_len`.

## Timing
- `io_in` change captured at clock edge k:
  - `s1` changes at k+1 and `s2` at k+2.
  - Bypass: `sync_out` changes at k+3.
  - Filtered: `sync_out` changes at k+3+N.
- `rise`/`fall` are coincident with the `sync_out` change.
- `ev_flag` is set on the clock after the `rise` or `fall` pulse.
- Minimum accepted pulse width with the filter enabled: N+1 clocks at `s2`.
- `rst` asserted mid-count: all state clears immediately, asynchronously. After release, a stable input reappears on `sync_out` 3+N cycles later.

## Configuration
- Macro `PIN_IN_SYNC_EVENT_EN`, defined:
  - `ev_flag[i]` sets on `rise[i]|fall[i]` and clears on `ev_clr[i]`.
  - Set has priority when set and clear occur in the same cycle.
- Macro not defined:
  - `ev_flag` is tied to 0 and `ev_clr` is ignored.
  - No flag flops are synthesized.
  - The port list is unchanged.

## Test plan
- Reset then bypass: `flt_en`=0, `io_in[0]` 0->1 at edge 10 -> `sync_out[0]`=1 and `rise[0]`=1 at edge 13; `rise[0]`=0 at edge 14.
- Filter accept: `flt_en[3]`=1, `flt_len`=4, `io_in[3]` held 1 from edge 20 -> `sync_out[3]` rises at edge 27; `fall[3]` pulses 7 cycles after `io_in[3]` returns to 0.
- Glitch reject: `flt_len`=4, `io_in[3]` high for 3 clocks then low -> `sync_out[3]` stays 0; no `rise`/`fall`; `cnt` returns to 0.
- Threshold lowered mid-count: `flt_len`=15, `s2` mismatched for 8 cycles, then `flt_len`=2 -> `sync_out` updates on the next clock.
- Events (macro defined): `rise[5]` pulses with `ev_clr[5]` asserted the cycle after -> `ev_flag[5]` stays 1. A later `ev_clr[5]` with no edge -> 0. Macro undefined -> `ev_flag` is always 0.
- Async reset: assert `rst` mid-filter-count with `sync_out`=1 -> all outputs 0 before the next clock edge; no `fall` pulse is generated.

Source files
------------

// File: rtl/pin_in_sync.sv
// Pad-input conditioning: 2-flop synchronizer, per-pin stability filter and edge detect.
// Define PIN_IN_SYNC_EVENT_EN to build the sticky per-pin edge-event flags.
module pin_in_sync #(
  parameter int COUNT = 32,
  parameter int FLT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [COUNT-1:0] io_in,
  input  logic [COUNT-1:0] flt_en,
  input  logic [FLT_W-1:0] flt_len,
  output logic [COUNT-1:0] sync_out,
  output logic [COUNT-1:0] rise,
  output logic [COUNT-1:0] fall,
  input  logic [COUNT-1:0] ev_clr,
  output logic [COUNT-1:0] ev_flag
);

  logic [COUNT-1:0]            s1;
  logic [COUNT-1:0]            s2;
  logic [COUNT-1:0]            next_sync;
  logic [COUNT-1:0][FLT_W-1:0] cnt;
  logic [COUNT-1:0][FLT_W-1:0] next_cnt;

  // Plain two-flop synchronizer; nothing may sit between s1 and s2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= io_in;
      s2 <= s1;
    end
  end

  // cnt holds how many samples s2 has already disagreed with sync_out;
  // the change is taken once that reaches flt_len (>= so a lowered threshold acts at once).
  always_comb begin
    next_sync = sync_out;
    next_cnt  = '0;
    for (int i = 0; i < COUNT; i++) begin
      if (!flt_en[i]) begin
        next_sync[i] = s2[i];
      end else if (s2[i] != sync_out[i]) begin
        if (cnt[i] >= flt_len) begin
          next_sync[i] = s2[i];
        end else begin
          next_cnt[i] = cnt[i] + 1'b1;
        end
      end
    end
  end

  // Edge pulses are registered alongside sync_out so they coincide with the new level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_out <= '0;
      cnt      <= '0;
      rise     <= '0;
      fall     <= '0;
    end else begin
      sync_out <= next_sync;
      cnt      <= next_cnt;
      rise     <= ~sync_out & next_sync;
      fall     <= sync_out & ~next_sync;
    end
  end

`ifdef PIN_IN_SYNC_EVENT_EN
  // Set wins over a simultaneous clear so no edge is ever lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ev_flag <= '0;
    end else begin
      ev_flag <= rise | fall | (ev_flag & ~ev_clr);
    end
  end
`else
  logic unused_ev_clr;
  assign unused_ev_clr = ^ev_clr;
  assign ev_flag       = '0;
`endif

endmodule

// File: tb/tb_pin_in_sync.sv
// Directed plus randomized bench for pin_in_sync against a sample-history reference model.
module tb_pin_in_sync;
  localparam int COUNT = 32;
  localparam int FLT_W = 4;
`ifdef PIN_IN_SYNC_EVENT_EN
  localparam logic EV = 1'b1;
`else
  localparam logic EV = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [COUNT-1:0] io_in = '0;
  logic [COUNT-1:0] flt_en = '0;
  logic [FLT_W-1:0] flt_len = '0;
  logic [COUNT-1:0] ev_clr = '0;
  logic [COUNT-1:0] sync_out, rise, fall, ev_flag;

  int checks = 0;
  int errors = 0;

  pin_in_sync #(.COUNT(COUNT), .FLT_W(FLT_W)) dut (
    .clk(clk), .rst(rst), .io_in(io_in), .flt_en(flt_en), .flt_len(flt_len),
    .sync_out(sync_out), .rise(rise), .fall(fall), .ev_clr(ev_clr), .ev_flag(ev_flag)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Reference model: raw samples reach the filter two clocks late; a pin's output
  // takes a new value once it has disagreed for flt_len+1 consecutive filtered samples.
  logic [COUNT-1:0]       dq[$];
  logic [COUNT-1:0]       m_out, m_rise, m_fall, m_flag;
  int                     m_streak[COUNT];
  logic [4*COUNT-1:0]     exp_q[$];

  task automatic model_reset();
    m_out = '0; m_rise = '0; m_fall = '0; m_flag = '0;
    for (int i = 0; i < COUNT; i++) m_streak[i] = 0;
    dq.delete();
    dq.push_back('0);
    dq.push_back('0);
  endtask

  task automatic model_step();
    logic [COUNT-1:0] seen, new_out, new_flag;
    if (rst) begin
      model_reset();
    end else begin
      seen = dq.pop_front();
      dq.push_back(io_in);
      new_out = m_out;
      for (int i = 0; i < COUNT; i++) begin
        if (!flt_en[i]) begin
          new_out[i]  = seen[i];
          m_streak[i] = 0;
        end else if (seen[i] == m_out[i]) begin
          m_streak[i] = 0;
        end else begin
          m_streak[i] = m_streak[i] + 1;
          if (m_streak[i] > int'(flt_len)) begin
            new_out[i]  = seen[i];
            m_streak[i] = 0;
          end
        end
      end
      new_flag = EV ? (m_rise | m_fall | (m_flag & ~ev_clr)) : '0;
      m_rise = ~m_out & new_out;
      m_fall = m_out & ~new_out;
      m_out  = new_out;
      m_flag = new_flag;
    end
    exp_q.push_back({m_out, m_rise, m_fall, m_flag});
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: model advances on the edge, DUT is compared on the falling edge.
  task automatic cycle();
    logic [4*COUNT-1:0] e;
    @(posedge clk);
    model_step();
    @(negedge clk);
    e = exp_q.pop_front();
    chk("sync_out", sync_out, e[4*COUNT-1:3*COUNT]);
    chk("rise",     rise,     e[3*COUNT-1:2*COUNT]);
    chk("fall",     fall,     e[2*COUNT-1:COUNT]);
    chk("ev_flag",  ev_flag,  e[COUNT-1:0]);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic edge_latency(input int pin, input bit want_rise, output int lat);
    lat = 99;
    for (int n = 1; n <= 20; n++) begin
      cycle();
      if (want_rise ? rise[pin] : fall[pin]) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    logic seen;
    model_reset();
    run(2);
    chk("reset_sync_out", sync_out, '0);
    chk("reset_flags", rise | fall | ev_flag, '0);
    rst = 1'b0;
    run(5);

    // Bypass latency on pin 0
    io_in[0] = 1'b1;
    run(2);
    chk("bypass_before", 32'(sync_out[0]), 32'd0);
    cycle();
    chk("bypass_sync", 32'(sync_out[0]), 32'd1);
    chk("bypass_rise", 32'(rise[0]), 32'd1);
    cycle();
    chk("bypass_rise_end", 32'(rise[0]), 32'd0);

    // Filter accept on pin 3 with N=4
    flt_en[3] = 1'b1;
    flt_len = 4'd4;
    io_in[3] = 1'b1;
    edge_latency(3, 1'b1, lat);
    chk("flt_rise_lat", lat, 32'd7);
    io_in[3] = 1'b0;
    edge_latency(3, 1'b0, lat);
    chk("flt_fall_lat", lat, 32'd7);
    run(3);

    // Glitch shorter than N+1 samples
    seen = 1'b0;
    io_in[3] = 1'b1;
    for (int k = 0; k < 3; k++) begin cycle(); seen |= sync_out[3] | rise[3] | fall[3]; end
    io_in[3] = 1'b0;
    for (int k = 0; k < 10; k++) begin cycle(); seen |= sync_out[3] | rise[3] | fall[3]; end
    chk("glitch_reject", 32'(seen), 32'd0);
    io_in[3] = 1'b1;
    edge_latency(3, 1'b1, lat);
    chk("glitch_recount_lat", lat, 32'd7);

    // Threshold lowered below the running count on pin 7
    flt_en[7] = 1'b1;
    flt_len = 4'd15;
    io_in[7] = 1'b1;
    run(10);
    chk("thr_hold", 32'(sync_out[7]), 32'd0);
    flt_len = 4'd2;
    cycle();
    chk("thr_lowered", 32'(sync_out[7]), 32'd1);
    flt_len = 4'd4;

    // Sticky event on pin 5: clear coinciding with the set loses
    io_in[5] = 1'b1;
    run(3);
    chk("ev_rise5", 32'(rise[5]), 32'd1);
    ev_clr[5] = 1'b1;
    cycle();
    ev_clr[5] = 1'b0;
    chk("ev_set_wins", 32'(ev_flag[5]), 32'(EV));
    cycle();
    chk("ev_sticky", 32'(ev_flag[5]), 32'(EV));
    ev_clr[5] = 1'b1;
    cycle();
    ev_clr[5] = 1'b0;
    chk("ev_cleared", 32'(ev_flag[5]), 32'd0);

    // Asynchronous reset in the middle of a falling count on pin 9
    flt_en[9] = 1'b1;
    io_in[9] = 1'b1;
    run(9);
    chk("ar_pre_high", 32'(sync_out[9]), 32'd1);
    io_in[9] = 1'b0;
    run(3);
    rst = 1'b1;
    #1;
    chk("ar_sync_out", sync_out, '0);
    chk("ar_pulses", rise | fall | ev_flag, '0);
    cycle();
    io_in[9] = 1'b1;
    rst = 1'b0;
    edge_latency(9, 1'b1, lat);
    chk("ar_recover_lat", lat, 32'd7);

    // Randomized traffic: slow toggling so filters both accept and reject
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < COUNT; i++)
        if ($urandom_range(0, 5) == 0) io_in[i] = ~io_in[i];
      if (k % 50 == 0) flt_en = $urandom;
      if ($urandom_range(0, 19) == 0) flt_len = 4'($urandom_range(0, 6));
      ev_clr = $urandom & $urandom;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
